// File: rtl/shift_reg_pkg.sv
// Shared types and defaults for the shift_reg_pipe delay line.
// Per-cycle operation decode with priority flush > load > shift(rotate) > hold.
package shift_reg_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_SHIFT,
    OP_ROTATE,
    OP_LOAD,
    OP_FLUSH
  } op_e;

  function automatic op_e decode_op(input logic flush,
                                    input logic load,
                                    input logic shift_en,
                                    input logic rotate);
    op_e op;
    if (flush)         op = OP_FLUSH;
    else if (load)     op = OP_LOAD;
    else if (shift_en) op = rotate ? OP_ROTATE : OP_SHIFT;
    else               op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/shift_reg_stage.sv
// One WIDTH-bit data + valid stage of the delay line with async active-high reset.
// Rotate is a shift whose source the parent selects, so both take the shift path here.
module shift_reg_stage
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  op_e              op,
  input  logic [WIDTH-1:0] shift_data,
  input  logic             shift_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] data_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] data_d;
  logic             valid_d;

  // Flush only clears the valid; stale data stays for consumers that ignore valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    unique case (op)
      OP_FLUSH: valid_d = 1'b0;
      OP_LOAD: begin
        data_d  = load_data;
        valid_d = 1'b1;
      end
      OP_SHIFT, OP_ROTATE: begin
        data_d  = shift_data;
        valid_d = shift_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/shift_reg_pipe.sv
// WIDTH x DEPTH delay line with per-stage valids, parallel load, flush, tap mux and fill counter.
// Optional rotate port enabled by defining SHIFT_REG_ROTATE_EN.
module shift_reg_pipe
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic                       rotate,
`endif
  input  logic                       shift_en,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       load,
  input  logic [WIDTH*DEPTH-1:0]     load_data,
  input  logic                       flush,
  input  logic [$clog2(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           tap_data,
  output logic                       tap_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_count
);

  localparam int unsigned TAP_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH+1);

  logic             rotate_req;
  op_e              op;
  logic [WIDTH-1:0] stage_data     [DEPTH];
  logic             stage_valid    [DEPTH];
  logic [WIDTH-1:0] shift_in_data  [DEPTH];
  logic             shift_in_valid [DEPTH];
  logic [FILL_W-1:0] fill_count_q, fill_count_d;

`ifdef SHIFT_REG_ROTATE_EN
  assign rotate_req = rotate;
`else
  assign rotate_req = 1'b0;
`endif

  always_comb op = decode_op(flush, load, shift_en, rotate_req);

  // Stage 0 takes the serial input, or the last stage when rotating.
  always_comb begin
    for (int unsigned i = 1; i < DEPTH; i++) begin
      shift_in_data[i]  = stage_data[i-1];
      shift_in_valid[i] = stage_valid[i-1];
    end
    if (op == OP_ROTATE) begin
      shift_in_data[0]  = stage_data[DEPTH-1];
      shift_in_valid[0] = stage_valid[DEPTH-1];
    end else begin
      shift_in_data[0]  = data_in;
      shift_in_valid[0] = in_valid;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    shift_reg_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .op          (op),
      .shift_data  (shift_in_data[g]),
      .shift_valid (shift_in_valid[g]),
      .load_data   (load_data[g*WIDTH +: WIDTH]),
      .data_q      (stage_data[g]),
      .valid_q     (stage_valid[g])
    );
  end

  // Count tracks the number of set valids, so the add/subtract cannot leave 0..DEPTH.
  always_comb begin
    fill_count_d = fill_count_q;
    unique case (op)
      OP_FLUSH: fill_count_d = '0;
      OP_LOAD:  fill_count_d = FILL_W'(DEPTH);
      OP_SHIFT: fill_count_d = fill_count_q + FILL_W'(in_valid)
                               - FILL_W'(stage_valid[DEPTH-1]);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fill_count_q <= '0;
    else     fill_count_q <= fill_count_d;
  end

  always_comb begin
    tap_data  = '0;
    tap_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_data  = stage_data[i];
        tap_valid = stage_valid[i];
      end
    end
  end

  assign data_out   = stage_data[DEPTH-1];
  assign out_valid  = stage_valid[DEPTH-1];
  assign fill_count = fill_count_q;

endmodule

// File: tb/tb_shift_reg_pipe.sv
// Self-checking bench for shift_reg_pipe (WIDTH=8, DEPTH=4) against a queue-based history model.
// Define SHIFT_REG_ROTATE_EN to also exercise the rotate feature.
module tb_shift_reg_pipe;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         rotate;
  logic         shift_en, in_valid, load, flush;
  logic [W-1:0] data_in;
  logic [W*D-1:0] load_data;
  logic [1:0]   tap_sel;
  logic [W-1:0] data_out, tap_data;
  logic         out_valid, tap_valid;
  logic [2:0]   fill_count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_data[$];
  logic         m_valid[$];

  always #5 clk = ~clk;

  shift_reg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SHIFT_REG_ROTATE_EN
    .rotate     (rotate),
`endif
    .shift_en   (shift_en),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .load       (load),
    .load_data  (load_data),
    .flush      (flush),
    .tap_sel    (tap_sel),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .tap_data   (tap_data),
    .tap_valid  (tap_valid),
    .fill_count (fill_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data.delete();
    m_valid.delete();
    for (int i = 0; i < D; i++) begin
      m_data.push_back('0);
      m_valid.push_back(1'b0);
    end
  endtask

  function automatic int model_fill();
    int n = 0;
    foreach (m_valid[i]) if (m_valid[i]) n++;
    return n;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".data_out"},  32'(data_out),   32'(m_data[D-1]));
    chk({tag, ".out_valid"}, 32'(out_valid),  32'(m_valid[D-1]));
    chk({tag, ".fill"},      32'(fill_count), 32'(model_fill()));
    chk({tag, ".tap_data"},  32'(tap_data),   32'(m_data[tap_sel]));
    chk({tag, ".tap_valid"}, 32'(tap_valid),  32'(m_valid[tap_sel]));
  endtask

  // Drive one cycle, advance the model by the same rules, then compare #1 after the edge.
  task automatic step(input logic se, input logic iv, input logic [W-1:0] di,
                      input logic ld, input logic fl, input logic rot, input string tag);
    logic [W-1:0] d;
    logic         v;
    shift_en = se; in_valid = iv; data_in = di; load = ld; flush = fl; rotate = rot;
    tap_sel  = 2'($urandom_range(0, D-1));
    @(posedge clk);
    if (fl) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
    end else if (ld) begin
      foreach (m_data[i]) begin
        m_data[i]  = load_data[i*W +: W];
        m_valid[i] = 1'b1;
      end
`ifdef SHIFT_REG_ROTATE_EN
    end else if (se && rot) begin
      d = m_data.pop_back();
      v = m_valid.pop_back();
      m_data.push_front(d);
      m_valid.push_front(v);
`endif
    end else if (se) begin
      void'(m_data.pop_back());
      void'(m_valid.pop_back());
      m_data.push_front(di);
      m_valid.push_front(iv);
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; rotate = 1'b0;
    shift_en = 0; in_valid = 0; data_in = '0; load = 0; flush = 0;
    load_data = '0; tap_sel = '0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Continuous stream 1..30.
    for (int n = 1; n <= 30; n++) begin
      step(1, 1, W'(n), 0, 0, 0, "stream");
      chk("stream.ovalid_const", 32'(out_valid), 32'(n >= D));
      chk("stream.fill_const", 32'(fill_count), 32'((n < D) ? n : D));
      if (n >= D) chk("stream.dout_const", 32'(data_out), 32'(n - D + 1));
    end

    // Async reset between edges clears everything before the next edge.
    #2;
    rst = 1'b1;
    #1;
    chk("areset.data_out", 32'(data_out), 0);
    chk("areset.out_valid", 32'(out_valid), 0);
    chk("areset.fill", 32'(fill_count), 0);
    chk("areset.tap_data", 32'(tap_data), 0);
    chk("areset.tap_valid", 32'(tap_valid), 0);
    rst = 1'b0;
    model_reset();
    for (int n = 1; n <= 6; n++) step(1, 1, W'(8'h50 + n), 0, 0, 0, "restart");

    // Idle gaps stretch latency.
    do_reset();
    step(1, 1, 8'h11, 0, 0, 0, "gap.in");
    for (int i = 0; i < 3; i++) step(0, $urandom_range(0, 1), W'($urandom), 0, 0, 0, "gap.idle");
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 8'h22, 0, 0, 0, "gap.shift");
      chk("gap.not_yet", 32'(out_valid), 0);
    end
    step(1, 1, 8'h22, 0, 0, 0, "gap.last");
    chk("gap.dout_const", 32'(data_out), 32'h11);
    chk("gap.ovalid_const", 32'(out_valid), 1);

    // Parallel load and tap readout.
    load_data = 32'h44332211;
    step(1, 1, 8'hEE, 1, 0, 0, "load");
    for (int t = 0; t < D; t++) begin
      tap_sel = 2'(t);
      #1;
      chk("load.tap_const", 32'(tap_data), 32'(8'h11 * (t + 1)));
      chk("load.tapv_const", 32'(tap_valid), 1);
    end
    chk("load.fill_const", 32'(fill_count), D);

    // Flush wins over load and shift; data stays.
    load_data = 32'hA5A5A5A5;
    step(1, 1, 8'h99, 1, 1, 0, "flush");
    chk("flush.fill_const", 32'(fill_count), 0);
    chk("flush.dout_const", 32'(data_out), 32'h44);

    // Alternating bubbles.
    do_reset();
    for (int i = 0; i < 12; i++) step(1, ~i[0], W'($urandom), 0, 0, 0, "bubble");
    chk("bubble.fill_const", 32'(fill_count), 2);

`ifdef SHIFT_REG_ROTATE_EN
    load_data = 32'h44332211;
    step(0, 0, '0, 1, 0, 0, "rot.load");
    for (int i = 0; i < D; i++) begin
      step(1, 1, W'($urandom), 0, 0, 1, "rot");
      chk("rot.fill_const", 32'(fill_count), D);
    end
    chk("rot.restored", 32'(data_out), 32'h44);
`endif

    // Random mix against the model.
    for (int i = 0; i < 300; i++) begin
      load_data = {$urandom};
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), W'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 3) == 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
